// File: rtl/norm_stream.sv
// Streaming L2 norm: accumulates squares of one frame of signed Q-format weights,
// then runs a digit-by-digit integer square root and presents a saturated norm.
module norm_stream #(
    parameter int N_WEIGHTS = 20,
    parameter int W         = 10,
    parameter int FRAC      = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_norm,
    output logic                out_sat,
    output logic                busy
);

    localparam int ACC_RAW = 2 * W + $clog2(N_WEIGHTS);
    localparam int ACC_W   = ACC_RAW + (ACC_RAW % 2);
    localparam int ROOT_W  = ACC_W / 2;
    localparam int REM_W   = ROOT_W + 3;
    localparam int CNT_W   = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1;
    localparam int IT_W    = $clog2(ROOT_W);
    localparam int MAX_POS = (1 << (W - 1)) - 1;

    if (FRAC >= W) begin : g_bad_frac
        $error("norm_stream: FRAC must be smaller than W");
    end

    typedef enum logic [1:0] {ACCUM, SQRT, OUT} state_t;

    state_t                  state, state_nx;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        rad;
    logic [CNT_W-1:0]        cnt;
    logic [IT_W-1:0]         iter;
    logic [REM_W-1:0]        rem;
    logic [ROOT_W-1:0]       root;

    logic signed [2*W-1:0]   din_ext;
    logic signed [2*W-1:0]   sq_s;
    logic [ACC_W-1:0]        sq;
    logic                    last_beat;
    logic                    last_iter;
    logic [REM_W-1:0]        rem_shift;
    logic [REM_W-1:0]        trial;
    logic [REM_W-1:0]        rem_nx;
    logic [ROOT_W-1:0]       root_nx;

    // Squaring at 2W bits keeps (-2^(W-1))^2 = 2^(2W-2) exact and non-negative.
    assign din_ext   = (2*W)'(in_data);
    assign sq_s      = din_ext * din_ext;
    assign sq        = ACC_W'($unsigned(sq_s));
    assign last_beat = in_valid && (cnt == CNT_W'(N_WEIGHTS - 1));
    assign last_iter = (iter == IT_W'(ROOT_W - 1));

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUT);
    assign busy      = (state != ACCUM);

    // One restoring root step: bring down two radicand bits, try subtracting 4*root+1.
    always_comb begin
        rem_shift = {rem[REM_W-3:0], rad[ACC_W-1 -: 2]};
        trial     = {1'b0, root, 2'b01};
        rem_nx    = rem_shift;
        root_nx   = {root[ROOT_W-2:0], 1'b0};
        if (rem_shift >= trial) begin
            rem_nx  = rem_shift - trial;
            root_nx = {root[ROOT_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:   if (last_beat) state_nx = SQRT;
            SQRT:    if (last_iter) state_nx = OUT;
            OUT:     if (out_ready) state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            rad      <= '0;
            rem      <= '0;
            root     <= '0;
            iter     <= '0;
            out_norm <= '0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (last_beat) begin
                        rad  <= acc + sq;
                        acc  <= '0;
                        cnt  <= '0;
                        rem  <= '0;
                        root <= '0;
                        iter <= '0;
                    end else if (in_valid) begin
                        acc <= acc + sq;
                        cnt <= cnt + 1'b1;
                    end
                end
                SQRT: begin
                    rad  <= rad << 2;
                    rem  <= rem_nx;
                    root <= root_nx;
                    iter <= iter + 1'b1;
                    // The root is in Q.FRAC already; only clipping to the signed range remains.
                    if (last_iter) begin
                        if (root_nx > ROOT_W'(MAX_POS)) begin
                            out_norm <= W'(MAX_POS);
                            out_sat  <= 1'b1;
                        end else begin
                            out_norm <= root_nx[W-1:0];
                            out_sat  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/norm_stream.md
Name: norm_stream

Overview:
- Sequential, parametrised successor to the combinational weight-norm block.
- Accepts a frame of N_WEIGHTS signed fixed-point weights, one per valid/ready beat, and accumulates their squares at full precision.
- Computes floor(sqrt(sum)) with an iterative digit-by-digit square root, then returns the L2 norm in the same Q format as the inputs, with saturation.
- Sits between the weight store and the normalisation/scaling stage.

Parameters:
- N_WEIGHTS, 20, weights per frame (>= 1).
- W, 10, weight and result width, signed two's complement.
- FRAC, 5, fractional bits of weights and result (Q(W-1-FRAC).FRAC).
- Derived: ACC_W = 2*W + $clog2(N_WEIGHTS), rounded up to even; ROOT_W = ACC_W/2. Defaults: ACC_W = 26, ROOT_W = 13.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  W  signed weight, Q.FRAC.
- out_valid  out  1  out_norm and out_sat are valid.
- out_ready  in  1  consumer accepts the result.
- out_norm  out  W  signed norm, Q.FRAC, always >= 0.
- out_sat  out  1  norm was clipped to the maximum positive value.
- busy  out  1  high in SQRT and OUT states.

Behaviour:
- Reset (async assert, sync release): state ACCUM, acc = 0, cnt = 0, in_ready = 1, out_valid = 0, out_norm = 0, out_sat = 0, busy = 0.
- FSM ACCUM:
  - in_ready = 1.
  - Handshake is in_valid & in_ready. On each handshake, acc += in_data*in_data (signed multiply, zero-extended to ACC_W, no overflow possible) and cnt++.
  - On the handshake with cnt == N_WEIGHTS-1, load the radicand with acc plus the final square, clear acc and cnt, and go to SQRT.
  - Cycles with in_valid = 0 are gaps; no state change.
- FSM SQRT:
  - in_ready = 0.
  - Runs a non-restoring or restoring digit-by-digit root, 2 radicand bits per cycle, for exactly ROOT_W cycles.
  - The final iteration registers the result and moves to OUT.
  - in_valid is ignored.
- FSM OUT:
  - out_valid = 1.
  - out_norm and out_sat are held stable until out_ready. Any in_valid that is already asserted stays pending.
  - On out_valid & out_ready, drop out_valid and return to ACCUM; in_ready = 1 from the next cycle.
- Arithmetic:
  - The sum of squares is in Q.(2*FRAC), so root = floor(sqrt(sum)) is directly the norm in Q.FRAC. No rounding up.
  - If root > 2^(W-1)-1: out_norm = 2^(W-1)-1 and out_sat = 1. Otherwise out_norm = root[W-1:0] and out_sat = 0.
- Latency: out_valid is high after the ROOT_W-th rising edge following the edge that accepted the last weight. This is 13 edges at defaults.
- Throughput: one frame per N_WEIGHTS + ROOT_W + 1 cycles when there is no input gap and no output stall.
- out_norm and out_sat keep their last value outside OUT. They are only updated on entry to OUT.
- Most negative input (-2^(W-1)) squares to 2^(2W-2) and must be handled exactly.
- N_WEIGHTS = 1: every accepted beat goes straight to SQRT.
- Reset mid-frame, mid-SQRT or in OUT: everything returns to reset values immediately. The partial frame is discarded and no out_valid pulse is produced.

Test Plan:
1. 20 weights all 0 -> out_norm = 0, out_sat = 0; out_valid rises exactly 13 edges after the last accept.
2. Weight[0] = 96 (3.0), others 0 -> sum 9216, out_norm = 96, out_sat = 0. Repeat with -96 -> 96.
3. Weights 96 and -128, others 0 -> sum 25600, out_norm = 160 (5.0). Weights 1 and 1 -> sum 2, out_norm = 1 (floor).
4. All 20 weights = -512 -> sum 5242880, root 2289, out_norm = 511, out_sat = 1.
5. Random in_valid gaps, plus out_ready held low 5 cycles in OUT -> in_ready = 0 throughout, out_norm stable; the next frame's first weight is accepted only after the out handshake; back-to-back frames give correct results.
6. Assert rst_n = 0 at accepted weight 10, then separately during SQRT cycle 6 -> outputs return to reset values at once, no out_valid; a subsequent full frame (weight 96 plus zeros) yields 96.
